// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: computes Diff = Sum - B (B zero-extended), one bit per clock, LSB first.
// Neg flags a final borrow; Fit flags a non-negative result that fits in 4 bits.
module subtractor_serial #(
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] Sum,
  input  logic [3:0]       B,
  output logic [SUM_W-1:0] Diff,
  output logic             Neg,
  output logic             Fit,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start, outputs hold last result
  // SHIFT | one result bit per cycle, SUM_W cycles
  // DONE  | single cycle, done pulse with fresh Diff/Neg/Fit
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CNT_W = $clog2(SUM_W + 1);

  state_t state, state_nxt;

  logic [SUM_W-1:0] s_sr, b_sr, d_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_bit, br_nxt, last;
  logic [SUM_W-1:0] d_final;

  always_comb begin
    d_bit   = s_sr[0] ^ b_sr[0] ^ br;
    br_nxt  = (~s_sr[0] & b_sr[0]) | (~(s_sr[0] ^ b_sr[0]) & br);
    last    = (cnt == CNT_W'(SUM_W - 1));
    d_final = {d_bit, d_sr[SUM_W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Neg  <= 1'b0;
      Fit  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s_sr <= Sum;
            b_sr <= SUM_W'(B);
            d_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          s_sr <= s_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_final;
          br   <= br_nxt;
          cnt  <= cnt + CNT_W'(1);
          // Results are committed only on the final bit so Diff never shows partial values.
          if (last) begin
            Diff <= d_final;
            Neg  <= br_nxt;
            Fit  <= ~br_nxt & (d_final <= SUM_W'(15));
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
